// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared defaults and types for the 2-read/1-write register file with pending-write scoreboard.
// Imported by the interface, the scoreboard sub-module and the top.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NREGS  = 32;
    localparam int DEFAULT_AW     = $clog2(DEFAULT_NREGS);
    localparam int ZERO_REG       = 0;

    typedef logic [DEFAULT_AW-1:0]     reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Decode-stage bus for the register file: writeback port, two read ports, scoreboard issue port.
// The master drives addresses/strobes; the slave (register file) returns data, busy flags and pend_cnt.
interface regfile_2r1w_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = DEFAULT_NREGS
) ();
    localparam int AW = $clog2(NREGS);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     rd_addr0;
    logic [AW-1:0]     rd_addr1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic              rd_busy0;
    logic              rd_busy1;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic [AW:0]       pend_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr0, rd_addr1, sb_set, sb_addr,
        input  rd_data0, rd_data1, rd_busy0, rd_busy1, pend_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr0, rd_addr1, sb_set, sb_addr,
        output rd_data0, rd_data1, rd_busy0, rd_busy1, pend_cnt
    );

endinterface

// File: rtl/regfile_2r1w_sb_scoreboard.sv
// Per-register pending-write flags plus a running count of pending registers.
// Register 0 and out-of-range indices never become pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_i,
    input  logic [$clog2(NREGS)-1:0]   set_addr_i,
    input  logic                       clr_i,
    input  logic [$clog2(NREGS)-1:0]   clr_addr_i,
    output logic [NREGS-1:0]           pending_o,
    output logic [$clog2(NREGS):0]     pend_cnt_o
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             setLive, clrLive, setNew, clrDrop;

    assign setLive = set_i && (set_addr_i != AW'(ZERO_REG)) && ({1'b0, set_addr_i} < NREGS_W);
    assign clrLive = clr_i && (clr_addr_i != AW'(ZERO_REG)) && ({1'b0, clr_addr_i} < NREGS_W);

    // A same-register set and clear is a new producer, so the flag stays up and the count holds.
    assign setNew  = setLive && !pending_q[set_addr_i];
    assign clrDrop = clrLive && pending_q[clr_addr_i] && !(setLive && (set_addr_i == clr_addr_i));

    always_comb begin
        pending_d = pending_q;
        if (clrLive) pending_d[clr_addr_i] = 1'b0;
        if (setLive) pending_d[set_addr_i] = 1'b1;
        pending_d[ZERO_REG] = 1'b0;

        cnt_d = cnt_q;
        case ({setNew, clrDrop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_o  = pending_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with hardwired-zero register 0 and a load-use pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data (and busy clear) to the read ports.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = DEFAULT_NREGS
) (
    input  logic             clk,
    input  logic             reset,
    regfile_2r1w_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pending;
    logic              wrLive;
    logic [AW-1:0]     rdAddr [2];
    logic [DATA_W-1:0] rdData [2];
    logic              rdBusy [2];

    function automatic logic inRange(input logic [AW-1:0] addr);
        return {1'b0, addr} < NREGS_W;
    endfunction

    assign wrLive = bus.wr_en && (bus.wr_addr != AW'(ZERO_REG)) && inRange(bus.wr_addr);

    always_comb begin
        regs_d = regs_q;
        if (wrLive) regs_d[bus.wr_addr] = bus.wr_data;
        regs_d[ZERO_REG] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else       regs_q <= regs_d;
    end

    regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .set_i      (bus.sb_set),
        .set_addr_i (bus.sb_addr),
        .clr_i      (bus.wr_en),
        .clr_addr_i (bus.wr_addr),
        .pending_o  (pending),
        .pend_cnt_o (bus.pend_cnt)
    );

    assign rdAddr[0] = bus.rd_addr0;
    assign rdAddr[1] = bus.rd_addr1;

    // Register 0 is stored as zero and never pending, so it needs no special case here.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (inRange(rdAddr[p])) begin
                rdData[p] = regs_q[rdAddr[p]];
                rdBusy[p] = pending[rdAddr[p]];
            end
`ifdef REGFILE_BYPASS_EN
            if (wrLive && (bus.wr_addr == rdAddr[p])) begin
                rdData[p] = bus.wr_data;
                rdBusy[p] = bus.sb_set && (bus.sb_addr == rdAddr[p]);
            end
`endif
        end
    end

    assign bus.rd_data0 = rdData[0];
    assign bus.rd_data1 = rdData[1];
    assign bus.rd_busy0 = rdBusy[0];
    assign bus.rd_busy1 = rdBusy[1];

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench for regfile_2r1w_sb: directed vectors queue expected read/busy/count values,
// a negedge monitor pops and compares them. Expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_2r1w_sb;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [31:0] X = 'x;

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t expQ [$];
    int   vectors = 0;
    int   miscompares = 0;

    regfile_2r1w_sb_if #(.DATA_W(DEFAULT_DATA_W), .NREGS(DEFAULT_NREGS)) bus ();

    regfile_2r1w_sb #(.DATA_W(DEFAULT_DATA_W), .NREGS(DEFAULT_NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (!$isunknown(exp)) begin
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
            end
        end
    endtask

    // Monitor: outputs are combinational/registered and settle before the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, ".rd_data0"}, 32'(bus.rd_data0), e.d0);
            checkOutput({e.name, ".rd_data1"}, 32'(bus.rd_data1), e.d1);
            checkOutput({e.name, ".rd_busy0"}, 32'(bus.rd_busy0), e.b0);
            checkOutput({e.name, ".rd_busy1"}, 32'(bus.rd_busy1), e.b1);
            checkOutput({e.name, ".pend_cnt"}, 32'(bus.pend_cnt), e.cnt);
        end
    end

    task automatic applyStimulus(
        input logic rst, input logic we, input reg_addr_t wa, input reg_data_t wd,
        input reg_addr_t ra0, input reg_addr_t ra1, input logic ss, input reg_addr_t sa,
        input string name, input logic [31:0] d0, input logic [31:0] d1,
        input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] cnt);
        exp_t e;
        reset        = rst;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr0 = ra0;
        bus.rd_addr1 = ra1;
        bus.sb_set   = ss;
        bus.sb_addr  = sa;
        if (name != "") begin
            e.name = name; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1; e.cnt = cnt;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, "", X, X, X, X, X);
        applyStimulus(1, 0, 0, 0, 5, 0, 0, 0, "reset_state", 0, 0, 0, 0, 0);

        // Populate, then reset with a colliding write/issue
        applyStimulus(0, 1, 1, 32'h11, 0, 0, 1, 11, "", X, X, X, X, X);
        applyStimulus(0, 1, 2, 32'h22, 0, 0, 1, 12, "cnt_after_one_set", 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 3, 32'h33, 1, 11, 1, 13, "read_before_reset", 32'h11, 0, 0, 1, 2);
        applyStimulus(1, 1, 1, 32'h55, 2, 12, 1, 14, "read_during_reset", 32'h22, 0, 0, 1, 3);
        applyStimulus(0, 0, 0, 0, 1, 12, 0, 0, "after_reset", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 3, 14, 0, 0, "reset_cleared_more", 0, 0, 0, 0, 0);

        // Write then read next cycle
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, "", X, X, X, X, X);
        applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, "write_then_read", 32'hDEADBEEF, 0, 0, 0, 0);

        // Register 0 ignores writes and issues
        applyStimulus(0, 1, 0, 32'hFFFF, 5, 0, 1, 0, "write_reg0_same", 32'hDEADBEEF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "reg0_after", 0, 0, 0, 0, 0);

        // Issue then writeback on reg 7
        applyStimulus(0, 0, 0, 0, 7, 0, 1, 7, "sb_set_issue", 0, X, 0, X, 0);
        applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, "busy_after_set", 0, X, 1, X, 1);
        applyStimulus(0, 1, 7, 32'hA0, 7, 0, 0, 0, "write_pending_same",
                      BYPASS ? 32'hA0 : 32'h0, X, BYPASS ? 32'd0 : 32'd1, X, 1);
        applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, "busy_cleared", 32'hA0, X, 0, X, 0);

        // Same-cycle set and clear on reg 3, then a redundant set
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, "", X, X, X, X, X);
        applyStimulus(0, 1, 3, 32'h77, 3, 0, 1, 3, "set_clr_same",
                      BYPASS ? 32'h77 : 32'h0, X, 1, X, 1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, "set_wins", 32'h77, X, 1, X, 1);
        applyStimulus(0, 0, 0, 0, 3, 0, 1, 3, "set_pending_again", 32'h77, X, 1, X, 1);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, "double_set_cnt", 32'h77, X, 1, X, 1);
        applyStimulus(0, 1, 3, 32'h78, 0, 0, 0, 0, "", X, X, X, X, X);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 0, "clear_after_write", 32'h78, X, 0, X, 0);

        // Set one register while clearing another: net count change zero
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 20, "", X, X, X, X, X);
        applyStimulus(0, 1, 20, 32'h20, 20, 21, 1, 21, "set_one_clr_other",
                      BYPASS ? 32'h20 : 32'h0, 0, BYPASS ? 32'd0 : 32'd1, 0, 1);
        applyStimulus(0, 0, 0, 0, 20, 21, 0, 0, "net_zero_change", 32'h20, 0, 0, 1, 1);

        // Bypass behaviour on a non-pending register, then with a same-cycle issue
        applyStimulus(0, 1, 9, 32'h1234, 9, 9, 0, 0, "bypass_write",
                      BYPASS ? 32'h1234 : 32'h0, BYPASS ? 32'h1234 : 32'h0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, "write_visible", 32'h1234, X, 0, X, 1);
        applyStimulus(0, 1, 9, 32'h5678, 9, 0, 1, 9, "bypass_with_set",
                      BYPASS ? 32'h5678 : 32'h1234, X, BYPASS ? 32'd1 : 32'd0, X, 1);
        applyStimulus(0, 0, 0, 0, 9, 21, 0, 0, "set_and_write_next", 32'h5678, 0, 1, 1, 2);

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
